// File: rtl/pipe_interlock.sv
// Hazard/forwarding scoreboard tracking in-flight GPR writes for DEPTH stages after ID, with MUL/DIV busy interlock.
// Optional PIPE_PERF_CNT_EN builds a saturating stall-cycle counter; otherwise stall_cycles is tied to zero.
module pipe_interlock #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int MD_LAT     = 4,
  parameter int SELW       = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wr_en,
  input  logic [AW-1:0]   id_wr_addr,
  input  logic            id_is_load,
  input  logic            id_is_md,
  input  logic            id_rd_hilo,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd_a,
  output logic [SELW-1:0] fwd_b,
  output logic            md_busy,
  output logic [31:0]     stall_cycles
);

  localparam int MDW = $clog2(MD_LAT+1);

  logic [DEPTH-1:0] slot_v;
  logic [DEPTH-1:0] slot_ld;
  logic [AW-1:0]    slot_addr [DEPTH];
  logic [MDW-1:0]   md_cnt;

  logic [SELW:0] res_a;
  logic [SELW:0] res_b;
  logic          hazard_a;
  logic          hazard_b;
  logic          md_hazard;
  logic          id_fire;

  // Returns {hazard, select}; scanning oldest to youngest lets the youngest producer win.
  function automatic logic [SELW:0] resolve(input logic [AW-1:0] src, input logic use_src);
    logic [SELW:0] r;
    r = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (slot_v[k] && (slot_addr[k] == src) && use_src && (src != '0)) begin
        if (slot_ld[k] && (k < LOAD_STAGE))
          r = {1'b1, {SELW{1'b0}}};
        else
          r = {1'b0, SELW'(k+1)};
      end
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(id_rs, id_use_rs);
    res_b = resolve(id_rt, id_use_rt);
  end

  assign hazard_a  = res_a[SELW];
  assign hazard_b  = res_b[SELW];
  assign fwd_a     = res_a[SELW-1:0];
  assign fwd_b     = res_b[SELW-1:0];
  assign md_busy   = (md_cnt != '0);
  assign md_hazard = id_valid & md_busy & (id_is_md | id_rd_hilo);
  assign stall     = id_valid & ~flush & (hazard_a | hazard_b | md_hazard);
  assign id_fire   = id_valid & ~stall & ~flush;

  // Slots advance every cycle; a stalled or flushed ID inserts a bubble into slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_v  <= '0;
      slot_ld <= '0;
      for (int k = 0; k < DEPTH; k++) slot_addr[k] <= '0;
    end else begin
      slot_v[0]    <= id_fire & id_wr_en & (id_wr_addr != '0);
      slot_addr[0] <= id_wr_addr;
      slot_ld[0]   <= id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        slot_v[k]    <= slot_v[k-1];
        slot_addr[k] <= slot_addr[k-1];
        slot_ld[k]   <= slot_ld[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_cnt <= '0;
    else if (id_fire && id_is_md)
      md_cnt <= MDW'(MD_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_interlock.sv
// Scoreboard bench for pipe_interlock: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_interlock;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_addr = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0;
  logic       id_is_load = 1'b0, id_is_md = 1'b0, id_rd_hilo = 1'b0, flush = 1'b0;

  logic        stall, md_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;
  logic        stall2, md_busy2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [31:0] stall_cycles2;

  always #5 clk = ~clk;

  pipe_interlock dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .id_rd_hilo(id_rd_hilo), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  // Second instance with the load result first forwardable from slot 2.
  pipe_interlock #(.LOAD_STAGE(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .id_rd_hilo(id_rd_hilo), .flush(flush),
    .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .md_busy(md_busy2), .stall_cycles(stall_cycles2)
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic        st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        busy;
    logic [31:0] sc;
    logic        c2;
    logic        st2;
    logic [1:0]  fa2;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests = 0;
  int   failed = 0;
  int   vidx = 0;
  logic [31:0] exp_sc = '0;
  logic        last_st = 1'b0;

  task automatic chk(input string nm, input logic [7:0] idx, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", nm, idx, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("stall",        me.idx, 32'(stall),   32'(me.st));
      chk("fwd_a",        me.idx, 32'(fwd_a),   32'(me.fa));
      chk("fwd_b",        me.idx, 32'(fwd_b),   32'(me.fb));
      chk("md_busy",      me.idx, 32'(md_busy), 32'(me.busy));
      chk("stall_cycles", me.idx, stall_cycles, me.sc);
      if (me.c2) begin
        chk("ls2_stall", me.idx, 32'(stall2), 32'(me.st2));
        chk("ls2_fwd_a", me.idx, 32'(fwd_a2), 32'(me.fa2));
      end
    end
  end

  // Applies one ID-stage vector just after the clock edge and queues what the outputs must be.
  task automatic vec(input logic rst, v, input logic [4:0] rs, rt, input logic urs, urt, we,
                     input logic [4:0] wa, input logic ld, md, hl, fl,
                     input logic est, input logic [1:0] efa, efb, input logic ebusy,
                     input logic c2, est2, input logic [1:0] efa2);
    @(posedge clk);
`ifdef PIPE_PERF_CNT_EN
    if (!reset && last_st && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
`endif
    if (reset) exp_sc = '0;
    #1;
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_is_md = md; id_rd_hilo = hl; flush = fl;
    if (rst) exp_sc = '0;
    last_st = est;
    vidx++;
    q.push_back('{idx: 8'(vidx), st: est, fa: efa, fb: efb, busy: ebusy, sc: exp_sc,
                  c2: c2, st2: est2, fa2: efa2});
  endtask

  task automatic nop(input logic ebusy);
    vec(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,ebusy, 0,0,0);
  endtask

  initial begin
    // reset state, including with live inputs presented
    vec(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 1,0,0);
    vec(1,1,3,3,1,1,1,3,0,0,0,0, 0,0,0,0, 1,0,0);
    nop(0);
    // ALU chain on $3, readers write $0
    vec(0,1,1,2,1,1,1,3,0,0,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,3,0,1,0,1,0,0,0,0,0, 0,1,0,0, 0,0,0);
    vec(0,1,3,0,1,0,1,0,0,0,0,0, 0,2,0,0, 0,0,0);
    vec(0,1,0,3,0,1,1,0,0,0,0,0, 0,0,3,0, 0,0,0);
    vec(0,1,3,0,1,0,1,0,0,0,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,0,0,1,1,1,0,0,0,0,0, 0,0,0,0, 0,0,0);
    // two writers of $7: youngest wins
    vec(0,1,0,0,0,0,1,7,0,0,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,0,0,0,0,1,7,0,0,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,7,7,1,1,0,0,0,0,0,0, 0,1,1,0, 0,0,0);
    nop(0); nop(0); nop(0);
    // load-use on $5, LOAD_STAGE=1 and LOAD_STAGE=2 side by side
    vec(0,1,0,0,0,0,1,5,1,0,0,0, 0,0,0,0, 1,0,0);
    vec(0,1,5,0,1,0,0,0,0,0,0,0, 1,0,0,0, 1,1,0);
    vec(0,1,5,0,1,0,0,0,0,0,0,0, 0,2,0,0, 1,1,0);
    vec(0,1,5,0,1,0,0,0,0,0,0,0, 0,3,0,0, 1,0,3);
    nop(0); nop(0); nop(0);
    // mult then mflo: four interlocked cycles
    vec(0,1,1,2,1,1,0,0,0,1,0,0, 0,0,0,0, 0,0,0);
    for (int i = 0; i < 4; i++) vec(0,1,0,0,0,0,1,8,0,0,1,0, 1,0,0,1, 0,0,0);
    vec(0,1,0,0,0,0,1,8,0,0,1,0, 0,0,0,0, 0,0,0);
    nop(0); nop(0); nop(0);
    // flush during load-use: bubble enters slot 0, flushed mult does not arm the counter
    vec(0,1,0,0,0,0,1,9,1,0,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,9,0,1,0,1,9,0,0,0,1, 0,0,0,0, 0,0,0);
    vec(0,1,9,0,1,0,0,0,0,0,0,0, 0,2,0,0, 0,0,0);
    vec(0,1,1,2,1,1,0,0,0,1,0,1, 0,0,0,0, 0,0,0);
    nop(0); nop(0);
    // reset asserted mid-operation with md_cnt=3 and $3 in flight
    vec(0,1,0,0,0,0,0,0,0,1,0,0, 0,0,0,0, 0,0,0);
    vec(0,1,0,0,0,0,1,3,0,0,0,0, 0,0,0,1, 0,0,0);
    vec(1,1,3,0,1,0,0,0,0,0,1,0, 0,0,0,0, 1,0,0);
    vec(0,1,3,0,1,0,0,0,0,0,1,0, 0,0,0,0, 1,0,0);
    nop(0);
    repeat (3) @(posedge clk);
    chk("queue_drained", 8'(vidx), 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_interlock.md
Name: pipe_interlock

Overview:
Parametrised hazard/forwarding scoreboard for the MIPS pipeline, replacing the fixed three-stage forwarding and hazard pair.
- Tracks in-flight register writes through DEPTH post-issue stages.
- Generates per-operand forwarding selects and a load-use stall for the ID stage.
- Adds what the old unit lacked: configurable load-ready stage, a multi-cycle MUL/DIV busy interlock, flush handling and an optional stall counter.

Parameters:
AW, 5, register address width (2**AW registers; address 0 is hardwired zero).
DEPTH, 3, tracked stages after ID (slot 0 = EX, slot DEPTH-1 = WB).
LOAD_STAGE, 1, first slot index whose load result is forwardable (1 = MEM output).
MD_LAT, 4, MUL/DIV unit latency in cycles (>=1).
SELW, $clog2(DEPTH+1), forwarding select width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  AW  source A address.
id_rt  in  AW  source B address.
id_use_rs  in  1  instruction reads rs.
id_use_rt  in  1  instruction reads rt.
id_wr_en  in  1  instruction writes a GPR.
id_wr_addr  in  AW  destination address.
id_is_load  in  1  instruction is a load.
id_is_md  in  1  instruction issues to MUL/DIV.
id_rd_hilo  in  1  instruction reads HI/LO (mfhi/mflo).
flush  in  1  kill the instruction in ID this cycle (taken branch/jump).
stall  out  1  hold IF/ID, insert bubble into EX.
fwd_a  out  SELW  0 = register file; k+1 = result of slot k.
fwd_b  out  SELW  same encoding for rt.
md_busy  out  1  MUL/DIV unit occupied.
stall_cycles  out  32  stall cycle count (see Optional Feature).

Behaviour:
Slot state:
- Each slot k holds {v, addr, ld}. Reset clears all v bits, the MD counter and stall_cycles.
- Reset outputs: stall=0, fwd_a=fwd_b=0, md_busy=0, stall_cycles=0. Reset mid-operation discards everything immediately, with no drain.

Issue (id_fire):
- id_fire = id_valid & !stall & !flush.
- On each clk edge, slot 0 <= {id_fire & id_wr_en & (id_wr_addr!=0), id_wr_addr, id_is_load}.
- Slots k>0 <= slot k-1 unconditionally; the pipeline never holds past ID.

Operand matching (combinational, per operand):
- match_k = slot k.v & (slot k.addr == src) & use_src & (src != 0).
- The lowest k with match_k wins (youngest producer).
- Winner has ld=1 and k<LOAD_STAGE: operand hazard, select 0.
- Otherwise select = k+1. With no match, select = 0.
- Slot DEPTH-1 (WB) is matched. Register-file write-through is not relied upon.

MUL/DIV interlock:
- md_cnt is a counter 0..MD_LAT; md_busy = (md_cnt != 0).
- md_hazard = id_valid & md_busy & (id_is_md | id_rd_hilo).
- On id_fire & id_is_md: md_cnt <= MD_LAT. Otherwise, if md_cnt != 0, md_cnt decrements.
- Issue and count-expiry in the same cycle: issue is blocked by md_hazard, so the two never coincide.

Stall and flush:
- stall = id_valid & !flush & (hazard_a | hazard_b | md_hazard).
- flush overrides stall: stall=0, bubble into slot 0, md_cnt not loaded.

Outputs:
- fwd_a/fwd_b are combinational from the current slots and ID inputs.
- They are valid even while stall=1; consumers ignore them then.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cycles increments by 1 on every clk edge where stall=1, saturating at 32'hFFFFFFFF, and is cleared by reset.
- Undefined: no counter register is built and stall_cycles is tied to 32'd0.

Test Plan:
- ALU chain: add $3 issued, next cycle add rs=$3 -> fwd_a=1, stall=0. One bubble later -> fwd_a=2. Two bubbles later -> fwd_a=3.
- Load-use: lw $5 issued, next instr rs=$5 -> stall=1 for exactly 1 cycle, then fwd_a=2 (slot 1). LOAD_STAGE=2 -> 2 stall cycles, then fwd_a=3.
- Zero register and priority: writes to $0 never set fwd. Two in-flight writers of $7 -> select picks slot 0 (fwd=1).
- MUL/DIV: mult issued, then mflo -> stall=1 for MD_LAT=4 cycles with md_busy=1, then md_busy=0 and mflo issues.
- Flush and reset: flush during a load-use hazard -> stall=0, slot 0 bubble. Reset asserted while md_cnt=3 -> md_busy=0 and all fwd=0 immediately, asynchronously.
- PIPE_PERF_CNT_EN defined: 5 stalled cycles -> stall_cycles=5. Undefined -> stall_cycles=0 throughout.
